// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: operand/hazard inputs in,
// stage enables, hold/flush strobes and statistics out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic             branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_hold;
  logic             idex_flush;
  logic             exmem_hold;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt, branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_hold, idex_flush, exmem_hold,
           halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt, branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_hold, idex_flush, exmem_hold,
           halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, taken-branch flush sequencing and data-memory wait freeze
// for the 5-stage pipe, with saturating statistics and a sticky timeout halt.
//
// state       | meaning
// ST_RUN      | normal issue; branch flush and load-use stall decoded here
// ST_FLUSH    | injecting the remaining branch-penalty bubbles
// ST_MEM_WAIT | last cycle(s) held on mem_busy; resumes RUN or FLUSH by pen_cnt
// ST_HALT     | memory timeout; pipe frozen until rst_n
module pipe_hazard_ctrl #(
  parameter int CNT_W          = 16,
  parameter int BRANCH_PENALTY = 1,
  parameter int MEM_TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_MEM_WAIT, ST_HALT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         pen_cnt_q, pen_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               halted_q, halted_d;

  logic pc_write, ifid_write, ifid_flush, idex_hold, idex_flush, exmem_hold;
  logic lu_haz, flush_mode, stall_inc, flush_inc;

  assign lu_haz = bus.idex_memread && (bus.idex_rt != 5'd0) &&
                  ((bus.idex_rt == bus.ifid_rs) ||
                   (bus.ifid_uses_rt && (bus.idex_rt == bus.ifid_rt)));

  // A wait that interrupted a branch penalty resumes the remaining bubbles.
  assign flush_mode = (state_q == ST_FLUSH) ||
                      ((state_q == ST_MEM_WAIT) && (pen_cnt_q != 3'd0));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_flush  = 1'b0;
    exmem_hold  = 1'b0;
    state_d     = state_q;
    pen_cnt_d   = pen_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    halted_d    = halted_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state_q == ST_HALT) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
    end else if (bus.mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
      stall_inc  = 1'b1;
      if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end else begin
        state_d    = ST_MEM_WAIT;
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else begin
      wait_cnt_d = '0;
      state_d    = ST_RUN;
      if (flush_mode) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        pen_cnt_d  = pen_cnt_q - 3'd1;
        state_d    = (pen_cnt_q == 3'd1) ? ST_RUN : ST_FLUSH;
      end else if (bus.branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
        if (BRANCH_PENALTY > 1) begin
          pen_cnt_d = 3'(BRANCH_PENALTY - 1);
          state_d   = ST_FLUSH;
        end
      end else if (lu_haz) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end
    end

    stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pen_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pen_cnt_q   <= pen_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.ifid_write = ifid_write;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_hold  = idex_hold;
  assign bus.idex_flush = idex_flush;
  assign bus.exmem_hold = exmem_hold;
  assign bus.halted     = halted_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: decode vector table, hand-written multi-cycle sequences,
// then random stimulus against a stateless-rule reference model.
module tb_pipe_hazard_ctrl;
  localparam int CW  = 4;
  localparam int PEN = 3;
  localparam int TO  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CW), .BRANCH_PENALTY(PEN), .MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // {pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_hold}
  localparam logic [5:0] O_IDLE  = 6'b110000;
  localparam logic [5:0] O_STALL = 6'b000100;
  localparam logic [5:0] O_FLUSH = 6'b111100;
  localparam logic [5:0] O_HOLD  = 6'b000011;
  localparam logic [5:0] O_RST   = 6'b001100;

  function automatic logic [5:0] outs();
    return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush,
            bus.idex_hold, bus.exmem_hold};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic uses, input logic br,
                       input logic busy);
    bus.idex_memread = mr;
    bus.idex_rt      = xrt;
    bus.ifid_rs      = rs;
    bus.ifid_rt      = rt;
    bus.ifid_uses_rt = uses;
    bus.branch_taken = br;
    bus.mem_busy     = busy;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference model: bubbles still owed, consecutive busy cycles, sticky halt.
  int m_bub, m_run, m_stall, m_flush;
  bit m_halt;

  task automatic model_reset();
    m_bub = 0; m_run = 0; m_stall = 0; m_flush = 0; m_halt = 0;
  endtask

  function automatic bit load_use();
    return bus.idex_memread && bus.idex_rt != 0 &&
           (bus.idex_rt == bus.ifid_rs || (bus.ifid_uses_rt && bus.idex_rt == bus.ifid_rt));
  endfunction

  function automatic logic [5:0] model_outs();
    if (m_halt || bus.mem_busy) return O_HOLD;
    if (m_bub > 0 || bus.branch_taken) return O_FLUSH;
    if (load_use()) return O_STALL;
    return O_IDLE;
  endfunction

  task automatic model_step();
    if (m_halt) return;
    if (bus.mem_busy) begin
      m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      m_run++;
      if (m_run >= TO) m_halt = 1;
    end else begin
      m_run = 0;
      if (m_bub > 0) m_bub--;
      else if (bus.branch_taken) begin
        m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        m_bub = PEN - 1;
      end else if (load_use()) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
    end
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Advance one clock; called at a negedge with inputs already applied.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       mr;
    logic [4:0] xrt, rs, rt;
    logic       uses, br, busy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[1]  = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, O_STALL};
    vecs[2]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, O_STALL};
    vecs[3]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[4]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, O_IDLE};
    vecs[5]  = '{1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, O_IDLE};
    vecs[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_FLUSH};
    vecs[7]  = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, O_FLUSH};
    vecs[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, O_HOLD};
    vecs[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, O_HOLD};
    vecs[10] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, O_HOLD};

    idle();
    rst_n = 1'b0;
    #2;
    chk("reset_outs", 16'(outs()), 16'(O_RST));
    chk("reset_halted", 16'(bus.halted), 16'd0);
    chk("reset_stall", 16'(bus.stall_cnt), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle decode from RUN
    foreach (vecs[i]) begin
      do_reset();
      drive(vecs[i].mr, vecs[i].xrt, vecs[i].rs, vecs[i].rt, vecs[i].uses,
            vecs[i].br, vecs[i].busy);
      #1;
      chk($sformatf("vec%0d_outs", i), 16'(outs()), 16'(vecs[i].exp));
      tick();
      idle();
    end

    // T1 load-use: exactly one stall cycle, counted once
    do_reset();
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("t1_stall", 16'(outs()), 16'(O_STALL));
    tick();
    idle();
    #1 chk("t1_after", 16'(outs()), 16'(O_IDLE));
    chk("t1_stall_cnt", 16'(bus.stall_cnt), 16'd1);

    // T3 branch with penalty 3
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    #1 chk("t3_b0", 16'(outs()), 16'(O_FLUSH));
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);  // wrong-path branch must be ignored
    #1 chk("t3_b1", 16'(outs()), 16'(O_FLUSH));
    tick();
    idle();
    #1 chk("t3_b2", 16'(outs()), 16'(O_FLUSH));
    tick();
    #1 chk("t3_run", 16'(outs()), 16'(O_IDLE));
    chk("t3_flush_cnt", 16'(bus.flush_cnt), 16'd1);

    // T4 memory wait during the flush: 5 held cycles, then the last bubble resumes
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    #1 chk("t4_f1", 16'(outs()), 16'(O_FLUSH));
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      #1 chk($sformatf("t4_hold%0d", i), 16'(outs()), 16'(O_HOLD));
      tick();
      idle();
      tick();  // release briefly so the timeout never fires with TO=4
    end
    // (3 held cycles in the loop, 2 more contiguous below)
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    idle();
    #1;
    chk("t4_halted", 16'(bus.halted), 16'd0);
    chk("t4_stall_cnt", 16'(bus.stall_cnt), 16'd5);
    chk("t4_flush_cnt", 16'(bus.flush_cnt), 16'd1);

    // Contiguous 5-cycle hold in a clean flush would exceed TO=4; check the
    // resume behaviour with a 3-cycle hold instead.
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("t4b_hold%0d", i), 16'(outs()), 16'(O_HOLD));
      tick();
    end
    idle();
    #1 chk("t4b_resume", 16'(outs()), 16'(O_FLUSH));
    tick();
    #1 chk("t4b_run", 16'(outs()), 16'(O_IDLE));
    chk("t4b_stall_cnt", 16'(bus.stall_cnt), 16'd3);

    // T5 timeout after the 4th busy cycle, sticky, cleared by async reset
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) chk("t5_not_yet", 16'(bus.halted), 16'd0);
      if (i == 4) chk("t5_halted", 16'(bus.halted), 16'd1);
    end
    idle();
    #1;
    chk("t5_sticky", 16'(bus.halted), 16'd1);
    chk("t5_halt_outs", 16'(outs()), 16'(O_HOLD));
    chk("t5_stall_cnt", 16'(bus.stall_cnt), 16'd4);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_halted", 16'(bus.halted), 16'd0);
    chk("t5_rst_stall", 16'(bus.stall_cnt), 16'd0);
    chk("t5_rst_outs", 16'(outs()), 16'(O_RST));
    @(negedge clk);
    rst_n = 1'b1;

    // T6 saturation of the 4-bit stall counter
    do_reset();
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    idle();
    #1 chk("t6_stall_sat", 16'(bus.stall_cnt), 16'(SAT));

    // Random stimulus against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (m_halt && $urandom_range(0, 3) == 0) begin
        rst_n = 1'b0;
        #1 chk("rnd_rst_outs", 16'(outs()), 16'(O_RST));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0));
      #1;
      chk("rnd_outs", 16'(outs()), 16'(model_outs()));
      chk("rnd_stall", 16'(bus.stall_cnt), 16'(m_stall));
      chk("rnd_flush", 16'(bus.flush_cnt), 16'(m_flush));
      chk("rnd_halted", 16'(bus.halted), 16'(m_halt));
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
